loop_filter: RTL and testbench
==============================

// Module: loop_filter
// PURPOSE
//  Digital PI loop filter of the ADPLL; sits directly downstream of tdc, in the ref_clk domain.
//  - Takes each 10-bit tdc phase_error sample {coarse[7:0], fine[1:0]} and subtracts a setpoint.
//  - Filters the result through proportional + integral paths and outputs a clamped DCO tuning word.
//  - An IDLE/ACQUIRE/TRACK gain-switching FSM with a lock detector selects high or low loop gain.
// PARAMETERS
//  TW          10   dco_ctrl width (bits)
//  INT_W       16   signed integrator width
//  DCO_CENTER  512  dco_ctrl reset/centre value
//  PHASE_TGT   512  phase_error setpoint; error e = phase_error - PHASE_TGT
//  KP_ACQ      0    proportional right-shift in ACQUIRE
//  KI_ACQ      2    integral right-shift in ACQUIRE
//  KP_TRK      2    proportional right-shift in TRACK
//  KI_TRK      5    integral right-shift in TRACK
//  LOCK_TOL    4    |e| <= LOCK_TOL counts as in-lock sample
//  LOCK_CNT    16   consecutive in-lock samples to enter TRACK
//  UNLOCK_TOL  32   |e| > UNLOCK_TOL counts as out-of-lock sample
//  UNLOCK_CNT  4    consecutive out-of-lock samples to fall back to ACQUIRE
// PORTS
//  ref_clk         in   1      single clock, all logic rising-edge
//  reset           in   1      asynchronous, active-high reset
//  phase_error     in   10     tdc output, unsigned
//  phase_valid     in   1      phase_error is a new sample this cycle
//  freeze          in   1      hold loop: ignore samples, hold all state
//  dco_ctrl        out  TW     DCO tuning word, unsigned
//  dco_ctrl_valid  out  1      one-cycle pulse when dco_ctrl updates
//  locked          out  1      1 while FSM is in TRACK
//  fsm_state       out  2      00 IDLE, 01 ACQUIRE, 10 TRACK
// BEHAVIOUR
//  - Reset (async, any time, including mid-pipeline):
//    - dco_ctrl=DCO_CENTER, dco_ctrl_valid=0, locked=0, fsm_state=IDLE.
//    - Integrator and lock/unlock counters = 0; in-flight samples discarded.
//  - Sample acceptance: sample accepted at edge k iff phase_valid=1 && freeze=0.
//    - freeze=1 drops the sample; integrator, counters, FSM and outputs are unchanged.
//  - Pipeline:
//    - Stage 1 at edge k: e = {1'b0,phase_error} - PHASE_TGT, 11-bit signed.
//    - Stage 2 at edge k+1: integrator, counters, FSM, dco_ctrl, dco_ctrl_valid and locked all update together.
//    - Latency 2 cycles. Back-to-back samples every cycle are supported, with one result per sample in order.
//  - Arithmetic (gains are those of the FSM state before the sample's update):
//    - Widen e by sign-extension to INT_W+2 bits.
//    - p = e >>> KP; integ_next = sat(integ + (e >>> KI)).
//    - sat clamps to [-(2^(INT_W-1)-1), 2^(INT_W-1)-1] (symmetric).
//    - sum = DCO_CENTER + p + integ_next, computed at INT_W+2 bits.
//    - dco_ctrl = clamp(sum, 0, 2^TW-1).
//    - Positive e raises dco_ctrl.
//  - FSM (evaluated per accepted sample):
//    - IDLE: first accepted sample -> ACQUIRE. That sample is processed with ACQUIRE gains.
//    - ACQUIRE: |e|<=LOCK_TOL increments lock_cnt, otherwise lock_cnt=0.
//      When lock_cnt reaches LOCK_CNT -> TRACK, locked=1, lock_cnt=0.
//    - TRACK: |e|>UNLOCK_TOL increments unlock_cnt, otherwise unlock_cnt=0.
//      When unlock_cnt reaches UNLOCK_CNT -> ACQUIRE, locked=0, unlock_cnt=0.
//    - Integrator is preserved across state changes.
//    - The state change is visible on locked/fsm_state in the same cycle as the triggering sample's dco_ctrl.
//  - Boundaries:
//    - e=-512 (phase_error=0) and e=+511 (phase_error=1023) are legal extremes.
//    - Output clamp and integrator saturation each hold at the limit, never wrap.
//    - freeze asserted while a sample is already in stage 1: that sample still completes.
// TESTING (TW=10, INT_W=16, defaults)
//  1 Reset: assert reset mid-stream -> dco_ctrl=512, dco_ctrl_valid=0, locked=0, fsm_state=00 immediately
//    (no clock edge needed).
//  2 First sample 520 -> fsm_state=01; 2 cycles later dco_ctrl=522 (p=8, integ=2), dco_ctrl_valid pulses
//    for 1 cycle.
//  3 After reset, one sample 0 -> e=-512, sum=-128 -> dco_ctrl=0 (clamped).
//  4 After reset, 16 consecutive samples 514 -> dco_ctrl=514 every sample.
//    locked=1 and fsm_state=10 on the 16th result; a 17th sample 514 gives dco_ctrl=512+0+0=512 (TRK gains).
//    Then 4 samples 600 -> locked=0 on the 4th result.
//  5 After reset, continuous samples 1023 (valid every cycle):
//    - integ +127 per sample until it saturates at 32767; never wraps negative.
//    - dco_ctrl=1023 from the first result.
//  6 With freeze=1, 8 samples of 1023 -> no dco_ctrl_valid pulse, dco_ctrl and fsm_state unchanged.
//    Deassert freeze, one sample 512 -> dco_ctrl = previous value recomputed with e=0.

Source files
------------

// File: rtl/loop_filter.sv
// ============================================================================
// loop_filter
// ----------------------------------------------------------------------------
// Digital PI loop filter of the ADPLL. Sits directly after the TDC in the
// reference clock domain.
//
// Each accepted TDC sample first has the phase setpoint subtracted from it.
// The resulting error then passes through a proportional path and an
// integral path. Their sum, taken around the DCO centre code, becomes a
// clamped DCO tuning word.
//
// A gain-switching FSM chooses the loop gain. IDLE and ACQUIRE use the high
// acquisition gains; TRACK uses the low tracking gains. A lock detector
// drives the FSM from the magnitude of the phase error.
//
// Ports
//   i_ref_clk         in   1    single clock, all logic on the rising edge
//   i_reset           in   1    asynchronous, active-high reset
//   i_phase_error     in   10   TDC output {coarse[7:0], fine[1:0]}, unsigned
//   i_phase_valid     in   1    i_phase_error carries a new sample this cycle
//   i_freeze          in   1    hold the loop: drop samples and keep all state
//   o_dco_ctrl        out  TW   DCO tuning word, unsigned
//   o_dco_ctrl_valid  out  1    one-cycle pulse when o_dco_ctrl updates
//   o_locked          out  1    high while the FSM is in TRACK
//   o_fsm_state       out  2    00 IDLE, 01 ACQUIRE, 10 TRACK
//
// Timing
//   A sample accepted at edge k produces its result at edge k+1. The
//   integrator, lock counters, FSM and all outputs update together at that
//   edge. A new sample may be accepted on every cycle.
// ============================================================================
module loop_filter #(
    parameter int TW         = 10,
    parameter int INT_W      = 16,
    parameter int DCO_CENTER = 512,
    parameter int PHASE_TGT  = 512,
    parameter int KP_ACQ     = 0,
    parameter int KI_ACQ     = 2,
    parameter int KP_TRK     = 2,
    parameter int KI_TRK     = 5,
    parameter int LOCK_TOL   = 4,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_TOL = 32,
    parameter int UNLOCK_CNT = 4
) (
    input  logic          i_ref_clk,
    input  logic          i_reset,
    input  logic [9:0]    i_phase_error,
    input  logic          i_phase_valid,
    input  logic          i_freeze,
    output logic [TW-1:0] o_dco_ctrl,
    output logic          o_dco_ctrl_valid,
    output logic          o_locked,
    output logic [1:0]    o_fsm_state
);

    // Internal arithmetic width. Two guard bits above the integrator let the
    // sums overflow into headroom, so saturation and clamping see the true
    // value instead of a wrapped one.
    localparam int AW   = INT_W + 2;
    localparam int LC_W = $clog2(LOCK_CNT + 1);
    localparam int UC_W = $clog2(UNLOCK_CNT + 1);

    localparam logic signed [AW-1:0] INT_MAX  = AW'(2 ** (INT_W - 1) - 1);
    localparam logic signed [AW-1:0] INT_MIN  = -INT_MAX;
    localparam logic signed [AW-1:0] DCO_MAXW = AW'(2 ** TW - 1);
    localparam logic signed [AW-1:0] CENTER_W = AW'(DCO_CENTER);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACQ  = 2'b01,
        ST_TRK  = 2'b10
    } state_t;

    // Symmetric saturation of the integrator to +/-(2^(INT_W-1)-1).
    function automatic logic signed [INT_W-1:0] sat_integ(input logic signed [AW-1:0] x);
        logic signed [AW-1:0] y;
        if (x > INT_MAX)
            y = INT_MAX;
        else if (x < INT_MIN)
            y = INT_MIN;
        else
            y = x;
        return y[INT_W-1:0];
    endfunction

    // Clamp the signed tuning sum to the unsigned DCO code range.
    function automatic logic [TW-1:0] clamp_dco(input logic signed [AW-1:0] x);
        logic [TW-1:0] y;
        if (x[AW-1])
            y = '0;
        else if (x > DCO_MAXW)
            y = '1;
        else
            y = x[TW-1:0];
        return y;
    endfunction

    // ------------------------------------------------------------------------
    // Stage 1: phase error against the setpoint
    // ------------------------------------------------------------------------
    logic signed [10:0] w_err_in;
    logic               w_accept;
    logic signed [10:0] r_err_p0;
    logic               r_vld_p0;

    assign w_err_in = $signed({1'b0, i_phase_error}) - $signed(11'(PHASE_TGT));
    assign w_accept = i_phase_valid & ~i_freeze;

    always_ff @(posedge i_ref_clk or posedge i_reset) begin
        if (i_reset)
            r_vld_p0 <= 1'b0;
        else
            r_vld_p0 <= w_accept;
    end

    always_ff @(posedge i_ref_clk) begin
        if (w_accept)
            r_err_p0 <= w_err_in;
    end

    // ------------------------------------------------------------------------
    // Stage 2: PI filter, lock detector, FSM and output registers
    // ------------------------------------------------------------------------
    state_t                   r_state;
    logic signed [INT_W-1:0]  r_integ;
    logic [LC_W-1:0]          r_lock_cnt;
    logic [UC_W-1:0]          r_unlock_cnt;
    logic [TW-1:0]            r_dco;
    logic                     r_dco_vld;
    logic                     r_locked;

    logic signed [AW-1:0]     w_err_w;
    logic signed [AW-1:0]     w_p;
    logic signed [AW-1:0]     w_i_inc;
    logic signed [AW-1:0]     w_integ_sum;
    logic signed [INT_W-1:0]  w_integ_next;
    logic signed [AW-1:0]     w_sum;
    logic [TW-1:0]            w_dco_next;
    logic [10:0]              w_abs_err;
    logic                     w_in_lock;
    logic                     w_out_lock;

    always_comb begin
        w_err_w = {{(AW - 11){r_err_p0[10]}}, r_err_p0};

        // IDLE shares the acquisition gains, so the very first sample is
        // already filtered the way ACQUIRE would filter it.
        if (r_state == ST_TRK) begin
            w_p     = w_err_w >>> KP_TRK;
            w_i_inc = w_err_w >>> KI_TRK;
        end else begin
            w_p     = w_err_w >>> KP_ACQ;
            w_i_inc = w_err_w >>> KI_ACQ;
        end

        w_integ_sum  = {{2{r_integ[INT_W-1]}}, r_integ} + w_i_inc;
        w_integ_next = sat_integ(w_integ_sum);
        w_sum        = CENTER_W + w_p + {{2{w_integ_next[INT_W-1]}}, w_integ_next};
        w_dco_next   = clamp_dco(w_sum);

        // |e| fits in 11 unsigned bits, even for e = -512.
        w_abs_err  = r_err_p0[10] ? $unsigned(-r_err_p0) : $unsigned(r_err_p0);
        w_in_lock  = (w_abs_err <= 11'(LOCK_TOL));
        w_out_lock = (w_abs_err >  11'(UNLOCK_TOL));
    end

    always_ff @(posedge i_ref_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_integ      <= '0;
            r_lock_cnt   <= '0;
            r_unlock_cnt <= '0;
            r_dco        <= TW'(DCO_CENTER);
            r_dco_vld    <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_dco_vld <= r_vld_p0;
            if (r_vld_p0) begin
                r_integ <= w_integ_next;
                r_dco   <= w_dco_next;
                case (r_state)
                    ST_IDLE, ST_ACQ: begin
                        // The sample that leaves IDLE already counts toward lock.
                        r_state <= ST_ACQ;
                        if (w_in_lock) begin
                            if (r_lock_cnt == LC_W'(LOCK_CNT - 1)) begin
                                r_state    <= ST_TRK;
                                r_locked   <= 1'b1;
                                r_lock_cnt <= '0;
                            end else begin
                                r_lock_cnt <= r_lock_cnt + LC_W'(1);
                            end
                        end else begin
                            r_lock_cnt <= '0;
                        end
                    end
                    ST_TRK: begin
                        if (w_out_lock) begin
                            if (r_unlock_cnt == UC_W'(UNLOCK_CNT - 1)) begin
                                r_state      <= ST_ACQ;
                                r_locked     <= 1'b0;
                                r_unlock_cnt <= '0;
                            end else begin
                                r_unlock_cnt <= r_unlock_cnt + UC_W'(1);
                            end
                        end else begin
                            r_unlock_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_locked   <= 1'b0;
                        r_lock_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_dco_ctrl       = r_dco;
    assign o_dco_ctrl_valid = r_dco_vld;
    assign o_locked         = r_locked;
    assign o_fsm_state      = r_state;

endmodule

// File: tb/tb_loop_filter.sv
// ============================================================================
// tb_loop_filter
// ----------------------------------------------------------------------------
// Directed bench for loop_filter with default parameters. When a sample is
// sent, its expected result (tuning word, locked, FSM state) is queued. A
// monitor on the falling clock edge pops and compares an entry each time the
// DUT pulses o_dco_ctrl_valid.
// ============================================================================
module tb_loop_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] phase_error;
    logic       phase_valid;
    logic       freeze;
    logic [9:0] dco_ctrl;
    logic       dco_ctrl_valid;
    logic       locked;
    logic [1:0] fsm_state;

    typedef struct {
        int dco;
        int lk;
        int st;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   nres  = 0;

    always #5 clk = ~clk;

    loop_filter dut (
        .i_ref_clk        (clk),
        .i_reset          (rst),
        .i_phase_error    (phase_error),
        .i_phase_valid    (phase_valid),
        .i_freeze         (freeze),
        .o_dco_ctrl       (dco_ctrl),
        .o_dco_ctrl_valid (dco_ctrl_valid),
        .o_locked         (locked),
        .o_fsm_state      (fsm_state)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (dco_ctrl_valid) begin
            check($sformatf("result_present[%0d]", nres), int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("dco[%0d]", nres), int'(dco_ctrl), e.dco);
                check($sformatf("locked[%0d]", nres), int'(locked), e.lk);
                check($sformatf("state[%0d]", nres), int'(fsm_state), e.st);
            end
            nres++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [9:0] pe, input int dco, input int lk, input int st);
        phase_error = pe;
        phase_valid = 1'b1;
        freeze      = 1'b0;
        q.push_back('{dco, lk, st});
        cyc(1);
    endtask

    task automatic idle(input int n);
        phase_valid = 1'b0;
        freeze      = 1'b0;
        cyc(n);
    endtask

    // Asynchronous reset between clock edges. The outputs are checked before
    // any edge arrives, and any in-flight expectations are dropped.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_dco"}, int'(dco_ctrl), 512);
        check({tag, "_vld"}, int'(dco_ctrl_valid), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_state"}, int'(fsm_state), 0);
        q.delete();
        phase_valid = 1'b0;
        freeze      = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1);
        check("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        phase_error = '0;
        phase_valid = 1'b0;
        freeze      = 1'b0;
        #1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("por_dco", int'(dco_ctrl), 512);
        check("por_vld", int'(dco_ctrl_valid), 0);
        check("por_locked", int'(locked), 0);
        check("por_state", int'(fsm_state), 0);

        // First sample 520: e=8, p=8, integ=2, so the tuning word is 522.
        // The result appears two edges after it is presented, as a single pulse.
        send(10'd520, 522, 0, 1);
        phase_valid = 1'b0;
        check("lat_not_early", int'(dco_ctrl_valid), 0);
        cyc(1);
        check("lat_vld", int'(dco_ctrl_valid), 1);
        check("lat_dco", int'(dco_ctrl), 522);
        check("lat_state", int'(fsm_state), 1);
        cyc(1);
        check("pulse_one_cycle", int'(dco_ctrl_valid), 0);
        idle(2);

        // Reset mid-stream: one result is visible and one sample is in stage 1.
        send(10'd520, 524, 0, 1);
        send(10'd520, 526, 0, 1);
        do_reset("rst_mid");
        idle(4);

        // e=-512: p=-512, integ=-128, so the sum of -128 clamps to 0.
        send(10'd0, 0, 0, 1);
        idle(3);
        drain();
        do_reset("rst_b");

        // Lock acquisition, one TRACK-gain sample, then loss of lock.
        for (int i = 0; i < 16; i++)
            send(10'd514, 514, (i == 15) ? 1 : 0, (i == 15) ? 2 : 1);
        send(10'd514, 512, 1, 2);
        send(10'd600, 536, 1, 2);
        send(10'd600, 538, 1, 2);
        send(10'd600, 540, 1, 2);
        send(10'd600, 542, 0, 1);
        idle(3);
        drain();

        // Frozen samples are dropped, and nothing moves.
        phase_error = 10'd1023;
        phase_valid = 1'b1;
        freeze      = 1'b1;
        cyc(8);
        check("frz_dco_held", int'(dco_ctrl), 542);
        check("frz_state_held", int'(fsm_state), 1);
        // e=0 with integ=8 held from before the freeze.
        send(10'd512, 520, 0, 1);
        // A sample already in stage 1 completes even though freeze rises behind it:
        // e=4, p=4, integ=9 gives 525.
        send(10'd516, 525, 0, 1);
        phase_error = 10'd1023;
        phase_valid = 1'b1;
        freeze      = 1'b1;
        cyc(4);
        check("frz_inflight_dco", int'(dco_ctrl), 525);
        idle(2);
        drain();
        do_reset("rst_c");

        // Continuous maximum positive error: integ +127 per sample. It saturates
        // after 259 samples; the output is pinned at 1023 throughout.
        for (int i = 0; i < 300; i++)
            send(10'd1023, 1023, 0, 1);
        // Unwind from saturation with e=-512: integ = 32767 - 128*n, and
        // dco = integ once it falls below 1023.
        for (int n = 1; n <= 252; n++)
            send(10'd0, (32767 - 128 * n > 1023) ? 1023 : (32767 - 128 * n), 0, 1);
        idle(3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
